io_out_port: RTL and testbench

//  - Output end of the accumulator I/O path: captures 16-bit accumulator results on a store strobe.
//  - Buffers the results in a small FIFO.
//  - Presents them to an external consumer over a valid/ready handshake.
//  - Sits between the accumulator's Output bus and the off-chip IOOut pins.
//  - Is the transmit-side counterpart to the IOIn feed.

---
 rtl/io_out_port_if.sv | 25 ++
 rtl/io_out_port.sv | 107 ++++++++++
 tb/tb_io_out_port.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/io_out_port_if.sv
// Handshake and status bundle between the accumulator output bus, the output FIFO and the IOOut pins.
interface io_out_port_if #(
  parameter int WIDTH = 16,
  parameter int PTR_W = 2
);
  logic [WIDTH-1:0] AccIn;
  logic             wr_en;
  logic [WIDTH-1:0] IOOut;
  logic             out_valid;
  logic             out_ready;
  logic             full;
  logic             empty;
  logic [PTR_W:0]   count;
  logic             drop;

  modport slave (
    input  AccIn, wr_en, out_ready,
    output IOOut, out_valid, full, empty, count, drop
  );

  modport master (
    output AccIn, wr_en, out_ready,
    input  IOOut, out_valid, full, empty, count, drop
  );
endinterface

// File: rtl/io_out_port.sv
// Output FIFO (first-word fall-through) between the accumulator store strobe and the IOOut consumer.
// Optional IO_OUT_DROP_CNT_EN adds a saturating 8-bit count of rejected writes (drop_count).
//
// state       | meaning
// ------------+------------------------------------------
// OCC_EMPTY   | count == 0, out_valid low, IOOut forced 0
// OCC_PARTIAL | 0 < count < DEPTH
// OCC_FULL    | count == DEPTH, writes need a same-edge pop
module io_out_port #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             CLK,
  input  logic             reset,
  io_out_port_if.slave     bus
`ifdef IO_OUT_DROP_CNT_EN
  ,
  output logic [7:0]       drop_count
`endif
);

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_t;

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ONE_C   = (PTR_W+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [PTR_W:0]   count_q;
  logic [PTR_W:0]   count_d;
  logic             drop_q;
  occ_t             occ;
  logic             push;
  logic             pop;
  logic             reject;

  always_comb begin
    occ = OCC_PARTIAL;
    if (count_q == '0)
      occ = OCC_EMPTY;
    else if (count_q == DEPTH_C)
      occ = OCC_FULL;
  end

  always_comb begin
    pop    = 1'b0;
    push   = 1'b0;
    reject = 1'b0;
    pop    = (occ != OCC_EMPTY) && bus.out_ready;
    push   = bus.wr_en && ((occ != OCC_FULL) || pop);
    reject = bus.wr_en && !push;
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      if (pop)
        head_q <= head_q + 1'b1;
      if (push)
        tail_q <= tail_q + 1'b1;
      count_q <= count_d;
      drop_q  <= reject;
    end
  end

  // Storage needs no reset: entries are only visible between tail write and head read.
  always_ff @(posedge CLK) begin
    if (!reset && push)
      mem[tail_q] <= bus.AccIn;
  end

`ifdef IO_OUT_DROP_CNT_EN
  always_ff @(posedge CLK) begin
    if (reset)
      drop_count <= 8'h00;
    else if (reject && (drop_count != 8'hFF))
      drop_count <= drop_count + 8'h01;
  end
`endif

  assign bus.empty     = (occ == OCC_EMPTY);
  assign bus.full      = (occ == OCC_FULL);
  assign bus.out_valid = (occ != OCC_EMPTY);
  assign bus.count     = count_q;
  assign bus.drop      = drop_q;
  assign bus.IOOut     = (occ == OCC_EMPTY) ? '0 : mem[head_q];

endmodule

// File: tb/tb_io_out_port.sv
// Directed bench for io_out_port: reset, FIFO ordering, full/drop, simultaneous push/pop, reset mid-drain.
module tb_io_out_port;
  logic CLK = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  io_out_port_if #(.WIDTH(16), .PTR_W(2)) bus ();

`ifdef IO_OUT_DROP_CNT_EN
  logic [7:0] drop_count;
`endif

  io_out_port #(.WIDTH(16), .DEPTH(4), .PTR_W(2)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus.slave)
`ifdef IO_OUT_DROP_CNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.wr_en     = 1'b1;
    bus.AccIn     = 16'hFF00;
    bus.out_ready = 1'b0;

    // 1: reset held, writes ignored
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_count", 32'(bus.count), 32'd0);
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_ioout", 32'(bus.IOOut), 32'd0);
      chk("rst_empty", 32'(bus.empty), 32'd1);
    end
    chk("rst_drop", 32'(bus.drop), 32'd0);
    chk("rst_full", 32'(bus.full), 32'd0);

    // 2: three pushes then drain in order
    reset = 1'b0;
    bus.AccIn = 16'hFF00; tick();
    chk("t2_lat_valid", 32'(bus.out_valid), 32'd1);
    chk("t2_lat_ioout", 32'(bus.IOOut), 32'h0000FF00);
    bus.AccIn = 16'h0001; tick();
    bus.AccIn = 16'h0002; tick();
    bus.wr_en = 1'b0;
    bus.AccIn = 16'hDEAD;
    chk("t2_count", 32'(bus.count), 32'd3);
    chk("t2_head", 32'(bus.IOOut), 32'h0000FF00);
    bus.out_ready = 1'b1;
    tick();
    chk("t2_out1", 32'(bus.IOOut), 32'h00000001);
    tick();
    chk("t2_out2", 32'(bus.IOOut), 32'h00000002);
    tick();
    chk("t2_empty", 32'(bus.empty), 32'd1);
    chk("t2_ioout0", 32'(bus.IOOut), 32'd0);
    chk("t2_valid0", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;

    // 3: fill, then rejected write (pointers have wrapped past the previous entries)
    bus.wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.AccIn = 16'hA000 + 16'(i);
      tick();
    end
    chk("t3_full", 32'(bus.full), 32'd1);
    chk("t3_count", 32'(bus.count), 32'd4);
    chk("t3_nodrop", 32'(bus.drop), 32'd0);
    bus.AccIn = 16'hBEEF;
    tick();
    chk("t3_drop", 32'(bus.drop), 32'd1);
    chk("t3_count_kept", 32'(bus.count), 32'd4);
    chk("t3_full_kept", 32'(bus.full), 32'd1);
    chk("t3_head", 32'(bus.IOOut), 32'h0000A000);
`ifdef IO_OUT_DROP_CNT_EN
    chk("t3_drop_count", 32'(drop_count), 32'd1);
`endif
    bus.wr_en = 1'b0;
    tick();
    chk("t3_drop_pulse", 32'(bus.drop), 32'd0);

    // 4: full with simultaneous push and pop
    bus.wr_en     = 1'b1;
    bus.AccIn     = 16'h1234;
    bus.out_ready = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    chk("t4_count", 32'(bus.count), 32'd4);
    chk("t4_nodrop", 32'(bus.drop), 32'd0);
    chk("t4_out1", 32'(bus.IOOut), 32'h0000A001);
    tick();
    chk("t4_out2", 32'(bus.IOOut), 32'h0000A002);
    tick();
    chk("t4_out3", 32'(bus.IOOut), 32'h0000A003);
    tick();
    chk("t4_out4", 32'(bus.IOOut), 32'h00001234);
    tick();
    chk("t4_empty", 32'(bus.empty), 32'd1);
    chk("t4_count0", 32'(bus.count), 32'd0);

    // 5: empty with wr_en and out_ready together
    bus.wr_en = 1'b1;
    bus.AccIn = 16'h5555;
    chk("t5_pre_valid", 32'(bus.out_valid), 32'd0);
    tick();
    bus.wr_en     = 1'b0;
    bus.out_ready = 1'b0;
    chk("t5_valid", 32'(bus.out_valid), 32'd1);
    chk("t5_ioout", 32'(bus.IOOut), 32'h00005555);
    chk("t5_count", 32'(bus.count), 32'd1);
    bus.out_ready = 1'b1;
    tick();
    chk("t5_empty", 32'(bus.empty), 32'd1);
    bus.out_ready = 1'b0;

    // 6: reset during drain discards stored words
    bus.wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.AccIn = 16'h0C01 + 16'(i);
      tick();
    end
    bus.wr_en     = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("t6_mid_head", 32'(bus.IOOut), 32'h00000C02);
    reset     = 1'b1;
    bus.wr_en = 1'b1;
    bus.AccIn = 16'h7777;
    tick();
    chk("t6_count", 32'(bus.count), 32'd0);
    chk("t6_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_ioout", 32'(bus.IOOut), 32'd0);
    reset     = 1'b0;
    bus.wr_en = 1'b0;
    tick();
    chk("t6_stale_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_stale_ioout", 32'(bus.IOOut), 32'd0);
    tick();
    chk("t6_stale_count", 32'(bus.count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
